// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: framer states, framing bytes, CRC-32.
// crc32_dibit() advances the reflected CRC by one RMII dibit, bit 0 first.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    function automatic logic [31:0] crc32_dibit(
        input logic [31:0] crc,
        input logic [1:0]  dibit
    );
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ dibit[i])
                c = (c >> 1) ^ CRC_POLY;
            else
                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_dibit_acc.sv
// Registered CRC-32 accumulator fed one dibit per clock.
// init has priority over en; reset leaves the register at CRC_INIT.
import eth_pkg::*;

module crc32_dibit_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [1:0]  dibit,
    output logic [31:0] crc_out
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            crc_out <= CRC_INIT;
        else if (init)
            crc_out <= CRC_INIT;
        else if (en)
            crc_out <= crc32_dibit(crc_out, dibit);
    end

endmodule

// File: rtl/rmii_tx_framer.sv
// RMII transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS, IFG.
// Drives LSB-first dibits on eth_refclk; aborts the frame on source underrun.
import eth_pkg::*;

module rmii_tx_framer #(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int APPEND_FCS      = 1,
    parameter int IFG_BYTES       = 12,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic [7:0]       axiid,
    input  logic             axiilast,
    output logic             axiir,
    output logic             axiov,
    output logic [1:0]       axiod,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun,
    output logic [CNT_W-1:0] frame_count
);

    localparam logic [31:0] PRE_LAST = 32'(4 * PREAMBLE_BYTES - 1);
    localparam logic [31:0] MIN_LEN  = 32'(MIN_FRAME_BYTES);
    localparam logic [31:0] IFG_CYC  = 32'(4 * IFG_BYTES);

    tx_state_t   state;
    logic [1:0]  dib_idx;
    logic [10:0] byte_cnt;
    logic [10:0] bc_inc;
    logic        cur_last;
    logic [29:0] sh;
    logic [15:0] cnt;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic        crc_init;
    logic        crc_en;
    logic        pad_done;
    logic        last_dib;

    assign bc_inc   = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign pad_done = {21'b0, bc_inc} >= MIN_LEN;
    assign crc_init = (state == IDLE) && axiiv;
    assign crc_en   = (state == DATA) || (state == PAD);
    assign crc_next = crc32_dibit(crc, axiod);
    assign busy     = (state != IDLE);

    assign axiir = (dib_idx == 2'd3) &&
                   ((state == SFD) || (state == DATA && !cur_last));

    // final payload dibit is next when no FCS follows
    assign last_dib = (dib_idx == 2'd2) && pad_done &&
                      ((state == PAD) || (state == DATA && cur_last));

    crc32_dibit_acc u_crc (
        .clk    (clk),
        .rst    (rst),
        .init   (crc_init),
        .en     (crc_en),
        .dibit  (axiod),
        .crc_out(crc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            dib_idx     <= 2'd0;
            byte_cnt    <= 11'd0;
            cur_last    <= 1'b0;
            sh          <= 30'd0;
            cnt         <= 16'd0;
            axiov       <= 1'b0;
            axiod       <= 2'b00;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (axiiv) begin
                        state    <= (PREAMBLE_BYTES > 0) ? PREAMBLE : SFD;
                        dib_idx  <= 2'd0;
                        cnt      <= 16'd0;
                        byte_cnt <= 11'd0;
                        axiov    <= 1'b1;
                        axiod    <= PREAMBLE_BYTE[1:0];
                    end
                end
                PREAMBLE: begin
                    if ({16'b0, cnt} >= PRE_LAST) begin
                        state   <= SFD;
                        dib_idx <= 2'd0;
                        axiod   <= SFD_BYTE[1:0];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SFD, DATA, PAD: begin
                    if (dib_idx != 2'd3) begin
                        dib_idx <= dib_idx + 2'd1;
                        sh      <= sh >> 2;
                        if (state == SFD)
                            axiod <= SFD_BYTE[{dib_idx + 2'd1, 1'b0} +: 2];
                        else
                            axiod <= sh[1:0];
                        if (APPEND_FCS == 0 && last_dib) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + CNT_W'(1);
                        end
                    end else if (state == PAD ||
                                 (state == DATA && cur_last)) begin
                        byte_cnt <= bc_inc;
                        if (!pad_done) begin
                            state   <= PAD;
                            dib_idx <= 2'd0;
                            sh      <= 30'd0;
                            axiod   <= 2'b00;
                        end else if (APPEND_FCS != 0) begin
                            // crc still lacks the dibit on the wire now
                            state <= FCS;
                            cnt   <= 16'd0;
                            axiod <= ~crc_next[1:0];
                            sh    <= ~crc_next[31:2];
                        end else begin
                            state <= IFG;
                            cnt   <= 16'd0;
                            axiov <= 1'b0;
                            axiod <= 2'b00;
                        end
                    end else if (axiiv) begin
                        state    <= DATA;
                        dib_idx  <= 2'd0;
                        axiod    <= axiid[1:0];
                        sh       <= {24'd0, axiid[7:2]};
                        cur_last <= axiilast;
                        if (state == DATA)
                            byte_cnt <= bc_inc;
                    end else begin
                        state    <= IFG;
                        cnt      <= 16'd0;
                        axiov    <= 1'b0;
                        axiod    <= 2'b00;
                        underrun <= 1'b1;
                    end
                end
                FCS: begin
                    axiod <= sh[1:0];
                    sh    <= sh >> 2;
                    cnt   <= cnt + 16'd1;
                    if (cnt == 16'd14) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + CNT_W'(1);
                    end
                    if (cnt == 16'd15) begin
                        state <= IFG;
                        cnt   <= 16'd0;
                        axiov <= 1'b0;
                        axiod <= 2'b00;
                    end
                end
                IFG: begin
                    // the IDLE cycle that follows completes the gap
                    if ({16'b0, cnt} + 32'd2 >= IFG_CYC)
                        state <= IDLE;
                    else
                        cnt <= cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_tx_framer.sv
// Directed bench for rmii_tx_framer: three parameterisations share the clock.
// u0 defaults, u1 without padding, u2 without FCS.
module tb_rmii_tx_framer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst;
    logic [2:0]  v;
    logic [2:0]  l;
    logic [7:0]  d [3];
    logic [2:0]  ir;
    logic [2:0]  ten;
    logic [5:0]  txd;
    logic [2:0]  bz;
    logic [2:0]  fd;
    logic [2:0]  ur;
    logic [47:0] fc;

    rmii_tx_framer u0 (
        .clk(clk), .rst(rst), .axiiv(v[0]), .axiid(d[0]),
        .axiilast(l[0]), .axiir(ir[0]), .axiov(ten[0]),
        .axiod(txd[1:0]), .busy(bz[0]), .frame_done(fd[0]),
        .underrun(ur[0]), .frame_count(fc[15:0])
    );

    rmii_tx_framer #(.MIN_FRAME_BYTES(0)) u1 (
        .clk(clk), .rst(rst), .axiiv(v[1]), .axiid(d[1]),
        .axiilast(l[1]), .axiir(ir[1]), .axiov(ten[1]),
        .axiod(txd[3:2]), .busy(bz[1]), .frame_done(fd[1]),
        .underrun(ur[1]), .frame_count(fc[31:16])
    );

    rmii_tx_framer #(.APPEND_FCS(0)) u2 (
        .clk(clk), .rst(rst), .axiiv(v[2]), .axiid(d[2]),
        .axiilast(l[2]), .axiir(ir[2]), .axiov(ten[2]),
        .axiod(txd[5:4]), .busy(bz[2]), .frame_done(fd[2]),
        .underrun(ur[2]), .frame_count(fc[47:32])
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] pay [$];
    logic       lst [$];
    logic [1:0] cap [$];
    logic [1:0] expd [$];
    logic [7:0] bq [$];

    int   fd_n, fd_pos, fd_cyc, rise_rel, gap;
    int   ur_n, ur_cyc, idle_rel, ten_n;
    logic ur_fall, timed_out;
    logic rs_pre_ten, rs_ten, rs_bz;
    logic [1:0] rs_pre_txd, rs_txd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++)
            expd.push_back(b[2*i +: 2]);
    endtask

    task automatic push_hdr();
        expd.delete();
        for (int i = 0; i < 7; i++)
            push_byte(8'h55);
        push_byte(8'hD5);
    endtask

    // textbook byte-wise reflected CRC-32 over bq, complemented
    function automatic logic [31:0] fcs_of();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < bq.size(); i++) begin
            c = c ^ {24'd0, bq[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic cmp_stream(input string tag);
        logic [31:0] mism;
        int n;
        mism = 32'hFFFFFFFF;
        n = (cap.size() < expd.size()) ? cap.size() : expd.size();
        for (int i = 0; i < n; i++)
            if (cap[i] !== expd[i] && mism == 32'hFFFFFFFF)
                mism = 32'(i);
        chk({tag, "_len"}, cap.size(), expd.size());
        chk({tag, "_first_bad_idx"}, mism, 32'hFFFFFFFF);
    endtask

    task automatic run(input int u, input int drop_at, input int nfd,
                       input int rst_at, input int budget);
        int   idx;
        int   c;
        logic pend;
        logic prev_ten;
        idx = 0; pend = 0; prev_ten = 0; c = 0;
        cap.delete();
        fd_n = 0; fd_pos = -1; fd_cyc = -1; rise_rel = -1; gap = 0;
        ur_n = 0; ur_cyc = -1; ur_fall = 0; idle_rel = -1; ten_n = 0;
        timed_out = 1;
        @(negedge clk);
        v[u] = 1'b1; d[u] = pay[0]; l[u] = lst[0];
        while (c < budget) begin
            @(negedge clk);
            if (ten[u]) begin
                cap.push_back(txd[2*u +: 2]);
                ten_n++;
            end
            if (fd[u]) begin
                fd_n++;
                if (fd_n == 1) begin
                    fd_pos = cap.size();
                    fd_cyc = c;
                end
            end
            if (fd_cyc >= 0 && c > fd_cyc && rise_rel < 0) begin
                if (ten[u]) rise_rel = c - fd_cyc;
                else gap++;
            end
            if (ur[u]) begin
                ur_n++;
                if (ur_cyc < 0) begin
                    ur_cyc = c;
                    ur_fall = prev_ten && !ten[u];
                end
            end
            if (ur_cyc >= 0 && idle_rel < 0 && !bz[u])
                idle_rel = c - ur_cyc;
            prev_ten = ten[u];
            if (rst_at > 0 && cap.size() == rst_at) begin
                rs_pre_ten = ten[u];
                rs_pre_txd = txd[2*u +: 2];
                rst = 1'b0;
                #1;
                rs_ten = ten[u];
                rs_txd = txd[2*u +: 2];
                rs_bz = bz[u];
                timed_out = 0;
                break;
            end
            if (nfd > 0 && fd_n >= nfd && !ten[u]) begin
                timed_out = 0;
                break;
            end
            if (nfd == 0 && rst_at == 0 && idle_rel >= 0) begin
                timed_out = 0;
                break;
            end
            if (pend) begin
                idx++;
                if (idx >= pay.size() || idx == drop_at) begin
                    v[u] = 1'b0;
                end else begin
                    d[u] = pay[idx];
                    l[u] = lst[idx];
                end
            end
            pend = v[u] & ir[u];
            c++;
        end
        v[u] = 1'b0;
    endtask

    task automatic load(input logic [7:0] b, input logic last);
        pay.push_back(b);
        lst.push_back(last);
    endtask

    task automatic build_t2();
        logic [31:0] f;
        pay.delete(); lst.delete(); bq.delete();
        for (int i = 0; i < 10; i++) begin
            load(8'(i), i == 9);
            bq.push_back(8'(i));
        end
        for (int i = 0; i < 50; i++)
            bq.push_back(8'h00);
        f = fcs_of();
        push_hdr();
        for (int i = 0; i < 60; i++)
            push_byte(bq[i]);
        for (int i = 0; i < 4; i++)
            push_byte(f[8*i +: 8]);
    endtask

    initial begin
        string s;
        rst = 1'b0;
        v = 3'b000; l = 3'b000;
        for (int i = 0; i < 3; i++) d[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txen", ten[0], 1'b0);
        chk("rst_txd", txd[1:0], 2'b00);
        chk("rst_busy", bz[0], 1'b0);
        chk("rst_ready", ir[0], 1'b0);
        chk("rst_done", fd[0], 1'b0);
        chk("rst_underrun", ur[0], 1'b0);
        chk("rst_count", fc[15:0], 16'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", bz[0], 1'b0);

        // 1: "123456789" without padding, FCS 26 39 F4 CB
        s = "123456789";
        pay.delete(); lst.delete();
        for (int i = 0; i < 9; i++) load(s[i], i == 8);
        push_hdr();
        for (int i = 0; i < 9; i++) push_byte(s[i]);
        push_byte(8'h26); push_byte(8'h39);
        push_byte(8'hF4); push_byte(8'hCB);
        run(1, -1, 1, 0, 1000);
        chk("t1_timeout", timed_out, 1'b0);
        cmp_stream("t1_stream");
        chk("t1_done_pos", fd_pos, 84);
        chk("t1_count", fc[31:16], 16'd1);

        // 6: 64-byte frame, no FCS
        pay.delete(); lst.delete();
        push_hdr();
        for (int i = 0; i < 64; i++) begin
            load(8'(i * 5 + 3), i == 63);
            push_byte(8'(i * 5 + 3));
        end
        run(2, -1, 1, 0, 1000);
        chk("t6_timeout", timed_out, 1'b0);
        cmp_stream("t6_stream");
        chk("t6_done_pos", fd_pos, 288);
        chk("t6_count", fc[47:32], 16'd1);

        // 2: 10 bytes padded to 60, golden FCS
        build_t2();
        run(0, -1, 1, 0, 1000);
        chk("t2_timeout", timed_out, 1'b0);
        chk("t2_txen_cycles", ten_n, 288);
        cmp_stream("t2_stream");
        chk("t2_done_pos", fd_pos, 288);
        chk("t2_count", fc[15:0], 16'd1);

        // 3: back-to-back frames, valid held high
        pay.delete(); lst.delete();
        for (int i = 0; i < 3; i++) load(8'hA0 + 8'(i), i == 2);
        for (int i = 0; i < 3; i++) load(8'hB0 + 8'(i), i == 2);
        run(0, -1, 2, 0, 1500);
        chk("t3_timeout", timed_out, 1'b0);
        chk("t3_frames", fd_n, 2);
        chk("t3_gap_low", gap, 48);
        chk("t3_rise_rel", rise_rel, 49);
        chk("t3_txen_cycles", ten_n, 576);
        chk("t3_count", fc[15:0], 16'd3);

        // 4: underrun at the 3rd byte request
        pay.delete(); lst.delete();
        for (int i = 0; i < 10; i++) load(8'h10 + 8'(i), i == 9);
        run(0, 2, 0, 0, 1000);
        chk("t4_timeout", timed_out, 1'b0);
        chk("t4_ur_pulses", ur_n, 1);
        chk("t4_txen_fall", ur_fall, 1'b1);
        chk("t4_txen_cycles", ten_n, 40);
        // IDLE is the 48th TX_EN-low cycle, counting the underrun cycle
        chk("t4_idle_rel", idle_rel, 47);
        chk("t4_count", fc[15:0], 16'd3);

        // 5: async reset mid-DATA, then a clean frame
        pay.delete(); lst.delete();
        for (int i = 0; i < 10; i++) load(8'hFF, i == 9);
        run(0, -1, 0, 50, 1000);
        chk("t5_timeout", timed_out, 1'b0);
        chk("t5_pre_txen", rs_pre_ten, 1'b1);
        chk("t5_pre_txd", rs_pre_txd, 2'b11);
        chk("t5_rst_txen", rs_ten, 1'b0);
        chk("t5_rst_txd", rs_txd, 2'b00);
        chk("t5_rst_busy", rs_bz, 1'b0);
        chk("t5_rst_count", fc[15:0], 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        build_t2();
        run(0, -1, 1, 0, 1000);
        chk("t5b_timeout", timed_out, 1'b0);
        cmp_stream("t5b_stream");
        chk("t5b_count", fc[15:0], 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
